// File: rtl/delay_pkg.sv
// Shared types and constants for the RAM-backed programmable sample delay line.
package delay_pkg;

  localparam int DEF_ADDRESS_WIDTH = 9;
  localparam int DEF_DATA_WIDTH    = 8;
  localparam int DEPTH             = 2 ** DEF_ADDRESS_WIDTH;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    CAPTURE,
    OUT
  } delay_state_t;

endpackage

// File: rtl/delay_ctrl.sv
// Sequences one write and one delayed read of the dual-port RAM per accepted sample,
// presenting the delayed sample on a valid/ready output.
module delay_ctrl
  import delay_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    in_data,
  input  logic [ADDRESS_WIDTH-1:0] offset,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     ram_write_en,
  output logic                     ram_read_en,
  output logic [ADDRESS_WIDTH-1:0] ram_write_addr,
  output logic [ADDRESS_WIDTH-1:0] ram_read_addr,
  output logic [DATA_WIDTH-1:0]    ram_din,
  input  logic [DATA_WIDTH-1:0]    ram_dout
);

  localparam logic [ADDRESS_WIDTH:0] FILL_FULL = {1'b1, {ADDRESS_WIDTH{1'b0}}};

  delay_state_t               state_q, state_d;
  logic [ADDRESS_WIDTH-1:0]   wptr_q;
  logic [ADDRESS_WIDTH:0]     fill_q;
  logic [DATA_WIDTH-1:0]      data_q;
  logic [ADDRESS_WIDTH-1:0]   off_q;
  logic [DATA_WIDTH-1:0]      out_data_q;
  logic                       primed;

  // A read is only meaningful once more than off_q samples have been written.
  assign primed = ({1'b0, off_q} < fill_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wptr_q     <= '0;
      fill_q     <= '0;
      data_q     <= '0;
      off_q      <= '0;
      out_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && in_valid) begin
        data_q <= in_data;
        off_q  <= offset;
      end
      if (state_q == WRITE && fill_q != FILL_FULL) begin
        fill_q <= fill_q + (ADDRESS_WIDTH + 1)'(1);
      end
      if (state_q == READ) begin
        wptr_q <= wptr_q + ADDRESS_WIDTH'(1);
      end
      if (state_q == CAPTURE) begin
        out_data_q <= primed ? ram_dout : '0;
      end
    end
  end

  // Strobes and addresses decode from registered state only; unused ones idle at zero.
  always_comb begin
    state_d        = state_q;
    in_ready       = 1'b0;
    out_valid      = 1'b0;
    ram_write_en   = 1'b0;
    ram_read_en    = 1'b0;
    ram_write_addr = '0;
    ram_read_addr  = '0;
    ram_din        = '0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = WRITE;
      end
      WRITE: begin
        ram_write_en   = 1'b1;
        ram_write_addr = wptr_q;
        ram_din        = data_q;
        state_d        = READ;
      end
      READ: begin
        ram_read_en   = 1'b1;
        ram_read_addr = wptr_q - off_q;
        state_d       = CAPTURE;
      end
      CAPTURE: begin
        state_d = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign out_data = out_data_q;

endmodule

// File: tb/tb_delay_ctrl.sv
// Self-checking bench for delay_ctrl with a behavioural registered-read RAM and output scoreboard.
module tb_delay_ctrl;

  localparam int AW = 9;
  localparam int DW = 8;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [AW-1:0] offset;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          ram_write_en;
  logic          ram_read_en;
  logic [AW-1:0] ram_write_addr;
  logic [AW-1:0] ram_read_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mem[2**AW];

  typedef struct {
    logic [DW-1:0] data;
    logic [AW-1:0] off;
    logic [DW-1:0] exp;
  } vec_t;
  vec_t tbl[6];

  delay_ctrl #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .offset         (offset),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .ram_write_en   (ram_write_en),
    .ram_read_en    (ram_read_en),
    .ram_write_addr (ram_write_addr),
    .ram_read_addr  (ram_read_addr),
    .ram_din        (ram_din),
    .ram_dout       (ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read RAM, write has priority.
  always @(posedge clk) begin
    if (ram_write_en) mem[ram_write_addr] <= ram_din;
    else if (ram_read_en) ram_dout <= mem[ram_read_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %0h expected none", out_data);
      end else begin
        chk("out_data", 32'(out_data), 32'(exp_q.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) chk("strobe_exclusive", 32'(ram_write_en & ram_read_en), 32'(0));
  end

  task automatic send(input logic [DW-1:0] d, input logic [AW-1:0] off, input logic [DW-1:0] e);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
    in_valid = 1'b1;
    in_data  = d;
    offset   = off;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = DW'($urandom);
    offset   = AW'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_remaining", 32'(exp_q.size()), 32'(0));
    exp_q.delete();
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] held;
    int n;
    in_valid  = 1'b0;
    in_data   = '0;
    offset    = '0;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    tbl[0] = '{8'h01, 9'd3, 8'h00};
    tbl[1] = '{8'h02, 9'd3, 8'h00};
    tbl[2] = '{8'h03, 9'd3, 8'h00};
    tbl[3] = '{8'h04, 9'd3, 8'h01};
    tbl[4] = '{8'h05, 9'd3, 8'h02};
    tbl[5] = '{8'h06, 9'd3, 8'h03};
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_out_data", 32'(out_data), 32'(0));
    chk("rst_strobes", 32'({ram_write_en, ram_read_en}), 32'(0));
    chk("rst_addr_din", 32'({ram_write_addr, ram_read_addr, ram_din}), 32'(0));
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Zero delay: cycle-accurate strobe and latency checks.
    send(8'h11, 9'd0, 8'h11);
    @(negedge clk);
    chk("zd_wr_en", 32'(ram_write_en), 32'(1));
    chk("zd_wr_addr", 32'(ram_write_addr), 32'(0));
    chk("zd_din", 32'(ram_din), 32'(8'h11));
    @(negedge clk);
    chk("zd_rd_en", 32'(ram_read_en), 32'(1));
    chk("zd_rd_addr", 32'(ram_read_addr), 32'(0));
    @(negedge clk);
    chk("zd_valid_t3", 32'(out_valid), 32'(0));
    @(negedge clk);
    chk("zd_valid_t4", 32'(out_valid), 32'(1));
    drain();

    // Asynchronous reset mid-stream (in WRITE).
    send(8'h55, 9'd0, 8'h55);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("arst_out_valid", 32'(out_valid), 32'(0));
    chk("arst_in_ready", 32'(in_ready), 32'(1));
    chk("arst_strobes", 32'({ram_write_en, ram_read_en}), 32'(0));
    chk("arst_out_data", 32'(out_data), 32'(0));
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Priming with offset 3 from table.
    for (int i = 0; i < 6; i++) send(tbl[i].data, tbl[i].off, tbl[i].exp);
    drain();

    // Backpressure in OUT.
    out_ready = 1'b0;
    send(8'h77, 9'd0, 8'h77);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_reach_out", 32'(out_valid), 32'(1));
    held = out_data;
    chk("bp_value", 32'(held), 32'(8'h77));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(out_valid), 32'(1));
      chk("bp_data_stable", 32'(out_data), 32'(held));
      chk("bp_in_ready", 32'(in_ready), 32'(0));
      chk("bp_strobes", 32'({ram_write_en, ram_read_en}), 32'(0));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_single_output", 32'(out_valid), 32'(0));
    chk("bp_queue_empty", 32'(exp_q.size()), 32'(0));

    // Wrap-around with offset 2.
    pulse_reset();
    for (int i = 0; i < 515; i++) begin
      send(8'(i), 9'd2, (i >= 2) ? 8'(i - 2) : 8'h00);
      if (i == 512) begin
        @(negedge clk);
        chk("wrap_wr_en", 32'(ram_write_en), 32'(1));
        chk("wrap_wr_addr", 32'(ram_write_addr), 32'(0));
        @(negedge clk);
        chk("wrap_rd_en", 32'(ram_read_en), 32'(1));
        chk("wrap_rd_addr", 32'(ram_read_addr), 32'(510));
      end
    end
    drain();

    // Reset during READ, then restart.
    pulse_reset();
    send(8'h01, 9'd1, 8'h00);
    send(8'h02, 9'd1, 8'h01);
    send(8'h03, 9'd1, 8'h02);
    send(8'h04, 9'd1, 8'h03);
    drain();
    send(8'h05, 9'd1, 8'h04);
    @(posedge clk);
    #1;
    chk("rr_in_read", 32'(ram_read_en), 32'(1));
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("rr_rd_en_cleared", 32'(ram_read_en), 32'(0));
    chk("rr_out_valid", 32'(out_valid), 32'(0));
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(8'hAA, 9'd1, 8'h00);
    @(negedge clk);
    chk("rr_wptr_restart", 32'(ram_write_addr), 32'(0));
    send(8'hBB, 9'd1, 8'hAA);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
